// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - IF stage: PC, instruction fetch, IF/ID register, branch redirect
// Redirect beats stall; a redirect drops the wrong-path word as a bubble in IF/ID.
module instr_fetch_unit #(
    parameter int                 ADDR_W   = 64,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic              redir_uncond,
    input  logic              redir_reg,
    input  logic [ADDR_W-1:0] redir_pc,
    input  logic [25:0]       redir_imm26,
    input  logic [18:0]       redir_imm19,
    input  logic [ADDR_W-1:0] redir_reg_val,
    output logic [31:0]       id_instr,
    output logic [10:0]       id_opcode,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_pc_plus4,
    output logic              id_valid,
    output logic [CNT_W-1:0]  fetch_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic [ADDR_W-1:0] pcReg;
    logic [ADDR_W-1:0] pcPlus4;
    logic [ADDR_W-1:0] offset26;
    logic [ADDR_W-1:0] offset19;
    logic [ADDR_W-1:0] redirTarget;
    logic [31:0]       idInstrReg;
    logic [ADDR_W-1:0] idPcReg;
    logic [ADDR_W-1:0] idPcPlus4Reg;
    logic              idValidReg;
    logic [CNT_W-1:0]  fetchCntReg;
    logic [CNT_W-1:0]  flushCntReg;

    assign pcPlus4 = pcReg + ADDR_W'(4);

    // Word offsets: sign-extend to full width, then scale by 4 (wraps mod 2^ADDR_W).
    assign offset26 = {{(ADDR_W-26){redir_imm26[25]}}, redir_imm26} << 2;
    assign offset19 = {{(ADDR_W-19){redir_imm19[18]}}, redir_imm19} << 2;

    always_comb begin
        redirTarget = redir_pc + offset19;
        if (redir_reg) begin
            redirTarget = redir_reg_val;
        end else if (redir_uncond) begin
            redirTarget = redir_pc + offset26;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pcReg        <= RESET_PC;
            idInstrReg   <= '0;
            idPcReg      <= '0;
            idPcPlus4Reg <= '0;
            idValidReg   <= 1'b0;
            fetchCntReg  <= '0;
            flushCntReg  <= '0;
        end else if (redirect) begin
            // id_pc/id_pc_plus4 keep their last values; only the valid word is squashed.
            pcReg       <= redirTarget;
            idInstrReg  <= '0;
            idValidReg  <= 1'b0;
            flushCntReg <= flushCntReg + CNT_W'(1);
        end else if (!stall) begin
            pcReg        <= pcPlus4;
            idInstrReg   <= imem_rdata;
            idPcReg      <= pcReg;
            idPcPlus4Reg <= pcPlus4;
            idValidReg   <= 1'b1;
            fetchCntReg  <= fetchCntReg + CNT_W'(1);
        end
    end

    assign imem_addr   = pcReg;
    assign id_instr    = idInstrReg;
    assign id_opcode   = idInstrReg[31:21];
    assign id_pc       = idPcReg;
    assign id_pc_plus4 = idPcPlus4Reg;
    assign id_valid    = idValidReg;
    assign fetch_cnt   = fetchCntReg;
    assign flush_cnt   = flushCntReg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - bench for instr_fetch_unit
module tb_instr_fetch_unit;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic        unc;
        logic        rreg;
        logic [63:0] rpc;
        logic [25:0] i26;
        logic [18:0] i19;
        logic [63:0] rval;
        logic [63:0] ePc;
        logic        eValid;
        logic [63:0] eIdPc;
        logic [63:0] ePlus4;
        logic [31:0] eFetch;
        logic [31:0] eFlush;
        logic        eBubble;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall, redirect, redir_uncond, redir_reg;
    logic [63:0] redir_pc, redir_reg_val;
    logic [25:0] redir_imm26;
    logic [18:0] redir_imm19;
    logic [31:0] id_instr;
    logic [10:0] id_opcode;
    logic [63:0] id_pc, id_pc_plus4;
    logic        id_valid;
    logic [31:0] fetch_cnt, flush_cnt;

    int passCnt = 0;
    int totalCnt = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [63:0] a);
        return 32'hD5A0_0000 ^ a[31:0];
    endfunction

    assign imem_rdata = word(imem_addr);

    instr_fetch_unit #(.ADDR_W(64), .RESET_PC(64'h0), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redir_uncond(redir_uncond),
        .redir_reg(redir_reg), .redir_pc(redir_pc), .redir_imm26(redir_imm26),
        .redir_imm19(redir_imm19), .redir_reg_val(redir_reg_val),
        .id_instr(id_instr), .id_opcode(id_opcode), .id_pc(id_pc),
        .id_pc_plus4(id_pc_plus4), .id_valid(id_valid),
        .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
    );

    function automatic vec_t mkv(
        input logic r, input logic s, input logic rd, input logic u, input logic rg,
        input logic [63:0] rpc, input logic [25:0] i26, input logic [18:0] i19,
        input logic [63:0] rval, input logic [63:0] pc, input logic v,
        input logic [63:0] idpc, input logic [63:0] p4, input logic [31:0] fc,
        input logic [31:0] fl);
        vec_t t;
        t.rst = r; t.stall = s; t.redir = rd; t.unc = u; t.rreg = rg;
        t.rpc = rpc; t.i26 = i26; t.i19 = i19; t.rval = rval;
        t.ePc = pc; t.eValid = v; t.eIdPc = idpc; t.ePlus4 = p4;
        t.eFetch = fc; t.eFlush = fl; t.eBubble = ~v;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    endtask

    task automatic applyVec(input vec_t t, input int idx);
        logic [31:0] eInstr;
        @(negedge clk);
        rst = t.rst; stall = t.stall; redirect = t.redir; redir_uncond = t.unc;
        redir_reg = t.rreg; redir_pc = t.rpc; redir_imm26 = t.i26;
        redir_imm19 = t.i19; redir_reg_val = t.rval;
        @(posedge clk);
        #1;
        eInstr = t.eBubble ? 32'h0 : word(t.eIdPc);
        chk("imem_addr", idx, imem_addr, t.ePc);
        chk("id_valid", idx, {63'h0, id_valid}, {63'h0, t.eValid});
        chk("id_pc", idx, id_pc, t.eIdPc);
        chk("id_pc_plus4", idx, id_pc_plus4, t.ePlus4);
        chk("id_instr", idx, {32'h0, id_instr}, {32'h0, eInstr});
        chk("id_opcode", idx, {53'h0, id_opcode}, {53'h0, eInstr[31:21]});
        chk("fetch_cnt", idx, {32'h0, fetch_cnt}, {32'h0, t.eFetch});
        chk("flush_cnt", idx, {32'h0, flush_cnt}, {32'h0, t.eFlush});
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redir_uncond = 1'b0; redir_reg = 1'b0;
        redir_pc = '0; redir_imm26 = '0; redir_imm19 = '0; redir_reg_val = '0;

        //          rst s  rd u  rg rpc         i26         i19       rval      pc        v  idpc      p4        fc fl
        vecs.push_back(mkv(0, 0, 0, 0, 0, 64'h0,    26'h0,       19'h0,     64'h0,   64'h0,    0, 64'h0,   64'h0,   0, 0));
        vecs.push_back(mkv(1, 0, 0, 0, 0, 64'h0,    26'h0,       19'h0,     64'h0,   64'h4,    1, 64'h0,   64'h4,   1, 0));
        vecs.push_back(mkv(1, 0, 0, 0, 0, 64'h0,    26'h0,       19'h0,     64'h0,   64'h8,    1, 64'h4,   64'h8,   2, 0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mkv(1, 1, 0, 0, 0, 64'h0, 26'h0,      19'h0,     64'h0,   64'h8,    1, 64'h4,   64'h8,   2, 0));
        vecs.push_back(mkv(1, 0, 0, 0, 0, 64'h0,    26'h0,       19'h0,     64'h0,   64'hC,    1, 64'h8,   64'hC,   3, 0));
        vecs.push_back(mkv(1, 0, 0, 0, 0, 64'h0,    26'h0,       19'h0,     64'h0,   64'h10,   1, 64'hC,   64'h10,  4, 0));
        vecs.push_back(mkv(1, 0, 1, 1, 0, 64'h10,   26'h3FFFFFC, 19'h0,     64'h0,   64'h0,    0, 64'hC,   64'h10,  4, 1));
        vecs.push_back(mkv(1, 0, 0, 0, 0, 64'h0,    26'h0,       19'h0,     64'h0,   64'h4,    1, 64'h0,   64'h4,   5, 1));
        vecs.push_back(mkv(1, 1, 1, 0, 0, 64'h20,   26'h0,       19'h3,     64'h0,   64'h2C,   0, 64'h0,   64'h4,   5, 2));
        vecs.push_back(mkv(1, 1, 0, 0, 0, 64'h0,    26'h0,       19'h0,     64'h0,   64'h2C,   0, 64'h0,   64'h4,   5, 2));
        vecs.push_back(mkv(1, 0, 0, 0, 0, 64'h0,    26'h0,       19'h0,     64'h0,   64'h30,   1, 64'h2C,  64'h30,  6, 2));
        vecs.push_back(mkv(1, 0, 1, 1, 1, 64'h50,   26'h5,       19'h7,     64'h400, 64'h400,  0, 64'h2C,  64'h30,  6, 3));
        vecs.push_back(mkv(1, 0, 0, 0, 0, 64'h0,    26'h0,       19'h0,     64'h0,   64'h404,  1, 64'h400, 64'h404, 7, 3));
        vecs.push_back(mkv(1, 0, 1, 0, 0, 64'h100,  26'h0,       19'h7FFFF, 64'h0,   64'hFC,   0, 64'h400, 64'h404, 7, 4));
        vecs.push_back(mkv(1, 0, 1, 1, 0, 64'h1000, 26'h10,      19'h0,     64'h0,   64'h1040, 0, 64'h400, 64'h404, 7, 5));
        vecs.push_back(mkv(1, 1, 0, 0, 0, 64'h0,    26'h0,       19'h0,     64'h0,   64'h1040, 0, 64'h400, 64'h404, 7, 5));
        vecs.push_back(mkv(0, 1, 0, 0, 0, 64'h0,    26'h0,       19'h0,     64'h0,   64'h0,    0, 64'h0,   64'h0,   0, 0));

        foreach (vecs[i]) applyVec(vecs[i], i);

        // PC increment wrap at the top of the address space
        applyVec(mkv(1, 0, 1, 0, 1, 64'h0, 26'h0, 19'h0, 64'hFFFF_FFFF_FFFF_FFFC,
                     64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 64'h0, 0, 1), 100);
        applyVec(mkv(1, 0, 0, 0, 0, 64'h0, 26'h0, 19'h0, 64'h0,
                     64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1, 1), 101);
        // Negative offset from PC 0 wraps below zero
        applyVec(mkv(1, 0, 1, 0, 0, 64'h0, 26'h0, 19'h7FFFF, 64'h0,
                     64'hFFFF_FFFF_FFFF_FFFC, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1, 2), 102);
        // Reset asserted together with a redirect
        applyVec(mkv(0, 0, 1, 1, 0, 64'h40, 26'h8, 19'h0, 64'h0,
                     64'h0, 0, 64'h0, 64'h0, 0, 0), 103);
        // Free-run from reset: id_pc 0,4,8,12 and fetch_cnt reaches 4
        for (int k = 0; k < 4; k++)
            applyVec(mkv(1, 0, 0, 0, 0, 64'h0, 26'h0, 19'h0, 64'h0,
                         64'(4 * (k + 1)), 1, 64'(4 * k), 64'(4 * (k + 1)), 32'(k + 1), 0), 110 + k);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
